// File: rtl/sram_bist_pkg.sv
// Shared types and the March C- element table for the 2-port SRAM BIST engine.
//   bist_state_t  : controller FSM state
//   march_op_t    : one March operation {rd, data_bit, dir_down, port_b}
//   MARCH_C_MINUS : ops per element (slot 1 unused for single-op elements)
//   MARCH_OPS     : number of valid ops per element
package sram_bist_pkg;

  localparam int unsigned ELEM_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FIN
  } bist_state_t;

  typedef struct packed {
    logic rd;        // 1: read-compare, 0: write
    logic data_bit;  // data background: 0 -> all-zeros, 1 -> all-ones
    logic dir_down;  // address order of the owning element
    logic port_b;    // issue on port B instead of port A
  } march_op_t;

  localparam march_op_t W0U = '{rd: 1'b0, data_bit: 1'b0, dir_down: 1'b0, port_b: 1'b0};
  localparam march_op_t W1U = '{rd: 1'b0, data_bit: 1'b1, dir_down: 1'b0, port_b: 1'b0};
  localparam march_op_t R0U = '{rd: 1'b1, data_bit: 1'b0, dir_down: 1'b0, port_b: 1'b0};
  localparam march_op_t R1U = '{rd: 1'b1, data_bit: 1'b1, dir_down: 1'b0, port_b: 1'b0};
  localparam march_op_t W0D = '{rd: 1'b0, data_bit: 1'b0, dir_down: 1'b1, port_b: 1'b0};
  localparam march_op_t W1D = '{rd: 1'b0, data_bit: 1'b1, dir_down: 1'b1, port_b: 1'b0};
  localparam march_op_t R0D = '{rd: 1'b1, data_bit: 1'b0, dir_down: 1'b1, port_b: 1'b0};
  localparam march_op_t R1D = '{rd: 1'b1, data_bit: 1'b1, dir_down: 1'b1, port_b: 1'b0};
  localparam march_op_t R0B = '{rd: 1'b1, data_bit: 1'b0, dir_down: 1'b0, port_b: 1'b1};

  localparam march_op_t [0:6][0:1] MARCH_C_MINUS = '{
    '{W0U, W0U},  // E0 up   : w0
    '{R0U, W1U},  // E1 up   : r0, w1
    '{R1U, W0U},  // E2 up   : r1, w0
    '{R0D, W1D},  // E3 down : r0, w1
    '{R1D, W0D},  // E4 down : r1, w0
    '{R0U, R0U},  // E5 up   : r0 (A)
    '{R0B, R0B}   // E6 up   : r0 (B)
  };

  localparam logic [0:6][1:0] MARCH_OPS = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1};

  localparam logic [ELEM_W-1:0] LAST_ELEM = 3'd6;

endpackage

// File: rtl/sram_bist_cmp_pipe.sv
// Read-compare pipeline: each read pushes {valid, expected, addr, elem, port}
// into an RD_LAT-deep shift register; at the tail the selected DOUT is
// compared and the first miscompare is latched.
//   clk, rst          : clock, synchronous active-high reset (also flushes)
//   clr               : clears the sticky fail record and flushes
//   push_*            : descriptor of the read issued this cycle
//   a_dout, b_dout    : macro read data
//   fail, fail_addr, fail_elem : first-miscompare record
module sram_bist_cmp_pipe
  import sram_bist_pkg::*;
#(
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push_valid,
  input  logic [DW-1:0]     push_exp,
  input  logic [AW-1:0]     push_addr,
  input  logic [ELEM_W-1:0] push_elem,
  input  logic              push_port,
  input  logic [DW-1:0]     a_dout,
  input  logic [DW-1:0]     b_dout,
  output logic              fail,
  output logic [AW-1:0]     fail_addr,
  output logic [ELEM_W-1:0] fail_elem
);

  typedef struct packed {
    logic              valid;
    logic [DW-1:0]     expd;
    logic [AW-1:0]     addr;
    logic [ELEM_W-1:0] elem;
    logic              port_b;
  } slot_t;

  slot_t         pipe [RD_LAT];
  slot_t         head;
  logic [DW-1:0] dout_sel;
  logic          miscmp;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int unsigned i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: push_valid, expd: push_exp, addr: push_addr,
                   elem: push_elem, port_b: push_port};
      for (int unsigned i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_comb begin
    head     = pipe[RD_LAT-1];
    dout_sel = head.port_b ? b_dout : a_dout;
    miscmp   = head.valid && (dout_sel != head.expd);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else if (miscmp && !fail) begin
      fail      <= 1'b1;
      fail_addr <= head.addr;
      fail_elem <= head.elem;
    end
  end

endmodule

// File: rtl/sram_2p_march_bist_ctrl.sv
// March C- BIST controller for one 2-port SRAM macro with BIST ports.
//   CLK, RST                 : clock, synchronous active-high reset
//   START                    : run request (honoured only when idle)
//   BUSY, DONE               : run in progress / sticky run complete
//   FAIL, FAIL_ADDR, FAIL_ELEM : sticky first-miscompare record
//   A_/B_BIST_*              : registered macro BIST drive (B used in E6 only)
//   A_DOUT, B_DOUT           : macro read data
module sram_2p_march_bist_ctrl
  import sram_bist_pkg::*;
#(
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic              FAIL,
  output logic [AW-1:0]     FAIL_ADDR,
  output logic [ELEM_W-1:0] FAIL_ELEM,
  output logic              A_BIST_EN,
  output logic              A_BIST_MEN,
  output logic              A_BIST_WEN,
  output logic              A_BIST_REN,
  output logic [AW-1:0]     A_BIST_ADDR,
  output logic [DW-1:0]     A_BIST_DIN,
  output logic [DW-1:0]     A_BIST_BM,
  output logic              B_BIST_EN,
  output logic              B_BIST_MEN,
  output logic              B_BIST_WEN,
  output logic              B_BIST_REN,
  output logic [AW-1:0]     B_BIST_ADDR,
  output logic [DW-1:0]     B_BIST_DIN,
  output logic [DW-1:0]     B_BIST_BM,
  input  logic [DW-1:0]     A_DOUT,
  input  logic [DW-1:0]     B_DOUT
);

  localparam int unsigned DCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  bist_state_t       state_q, state_d;
  logic [DCW-1:0]    drain_q;
  logic [ELEM_W-1:0] elem_q, elem_d, elem_nx;
  logic              op_q, op_d;
  logic [AW-1:0]     addr_q, addr_d;
  march_op_t         cur_op;
  logic              dir_down, op_last, addr_term, run_last;
  logic              start_ok, issue, busy_d, done_set;
  logic              push_valid;
  logic [DW-1:0]     push_exp;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= (state_q == ST_DRAIN) ? drain_q + DCW'(1) : '0;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (START) state_d = ST_RUN;
      ST_RUN:   if (run_last) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q == DCW'(RD_LAT - 1)) state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode. The first op is issued on the START edge itself, so RUN
  // spans exactly the issue cycles and DRAIN covers the read latency.
  always_comb begin
    start_ok = (state_q == ST_IDLE) && START;
    issue    = start_ok || (state_q == ST_RUN);
    busy_d   = (state_d != ST_IDLE);
    done_set = (state_q == ST_FIN);
  end

  // Element / op / address sequencing
  always_comb begin
    cur_op    = MARCH_C_MINUS[elem_q][op_q];
    dir_down  = MARCH_C_MINUS[elem_q][0].dir_down;
    op_last   = ({1'b0, op_q} + 2'd1) == MARCH_OPS[elem_q];
    addr_term = dir_down ? (addr_q == '0) : (addr_q == '1);
    run_last  = (elem_q == LAST_ELEM) && op_last && addr_term;
    elem_nx   = elem_q + ELEM_W'(1);
    elem_d    = elem_q;
    op_d      = op_q;
    addr_d    = addr_q;
    if (!op_last) begin
      op_d = 1'b1;
    end else begin
      op_d = 1'b0;
      if (run_last) begin
        elem_d = '0;
        addr_d = '0;
      end else if (addr_term) begin
        elem_d = elem_nx;
        addr_d = MARCH_C_MINUS[elem_nx][0].dir_down ? '1 : '0;
      end else begin
        addr_d = dir_down ? addr_q - AW'(1) : addr_q + AW'(1);
      end
    end
    push_valid = issue && cur_op.rd;
    push_exp   = {DW{cur_op.data_bit}};
  end

  always_ff @(posedge CLK) begin
    if (RST || !issue) begin
      elem_q <= '0;
      op_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      elem_q <= elem_d;
      op_q   <= op_d;
      addr_q <= addr_d;
    end
  end

  // Registered macro drive and status
  always_ff @(posedge CLK) begin
    if (RST) begin
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      A_BIST_EN   <= 1'b0;
      B_BIST_EN   <= 1'b0;
      A_BIST_MEN  <= 1'b0;
      A_BIST_WEN  <= 1'b0;
      A_BIST_REN  <= 1'b0;
      A_BIST_ADDR <= '0;
      A_BIST_DIN  <= '0;
      B_BIST_MEN  <= 1'b0;
      B_BIST_WEN  <= 1'b0;
      B_BIST_REN  <= 1'b0;
      B_BIST_ADDR <= '0;
      B_BIST_DIN  <= '0;
    end else begin
      BUSY        <= busy_d;
      A_BIST_EN   <= busy_d;
      B_BIST_EN   <= busy_d;
      if (start_ok)      DONE <= 1'b0;
      else if (done_set) DONE <= 1'b1;
      A_BIST_MEN  <= 1'b0;
      A_BIST_WEN  <= 1'b0;
      A_BIST_REN  <= 1'b0;
      A_BIST_ADDR <= '0;
      A_BIST_DIN  <= '0;
      B_BIST_MEN  <= 1'b0;
      B_BIST_WEN  <= 1'b0;
      B_BIST_REN  <= 1'b0;
      B_BIST_ADDR <= '0;
      B_BIST_DIN  <= '0;
      if (issue) begin
        if (cur_op.port_b) begin
          B_BIST_MEN  <= 1'b1;
          B_BIST_WEN  <= !cur_op.rd;
          B_BIST_REN  <= cur_op.rd;
          B_BIST_ADDR <= addr_q;
          B_BIST_DIN  <= push_exp;
        end else begin
          A_BIST_MEN  <= 1'b1;
          A_BIST_WEN  <= !cur_op.rd;
          A_BIST_REN  <= cur_op.rd;
          A_BIST_ADDR <= addr_q;
          A_BIST_DIN  <= push_exp;
        end
      end
    end
  end

  assign A_BIST_BM = '1;
  assign B_BIST_BM = '1;

  sram_bist_cmp_pipe #(
    .AW     (AW),
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_cmp (
    .clk        (CLK),
    .rst        (RST),
    .clr        (start_ok),
    .push_valid (push_valid),
    .push_exp   (push_exp),
    .push_addr  (addr_q),
    .push_elem  (elem_q),
    .push_port  (cur_op.port_b),
    .a_dout     (A_DOUT),
    .b_dout     (B_DOUT),
    .fail       (FAIL),
    .fail_addr  (FAIL_ADDR),
    .fail_elem  (FAIL_ELEM)
  );

endmodule

// File: tb/tb_sram_2p_march_bist_ctrl.sv
// Bench for sram_2p_march_bist_ctrl: behavioural 2-port memory with
// selectable faults, table of run vectors plus reset/START corner sequences.
module tb_sram_2p_march_bist_ctrl;

  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int RD_LAT  = 2;
  localparam int DEPTH   = 256;
  localparam int NOMINAL = 11 * DEPTH + RD_LAT;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic          BUSY, DONE, FAIL;
  logic [AW-1:0] FAIL_ADDR;
  logic [2:0]    FAIL_ELEM;
  logic          A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN;
  logic [AW-1:0] A_BIST_ADDR;
  logic [DW-1:0] A_BIST_DIN, A_BIST_BM;
  logic          B_BIST_EN, B_BIST_MEN, B_BIST_WEN, B_BIST_REN;
  logic [AW-1:0] B_BIST_ADDR;
  logic [DW-1:0] B_BIST_DIN, B_BIST_BM;
  logic [DW-1:0] A_DOUT, B_DOUT;

  always #5 CLK = ~CLK;

  sram_2p_march_bist_ctrl #(
    .AW     (AW),
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .FAIL        (FAIL),
    .FAIL_ADDR   (FAIL_ADDR),
    .FAIL_ELEM   (FAIL_ELEM),
    .A_BIST_EN   (A_BIST_EN),
    .A_BIST_MEN  (A_BIST_MEN),
    .A_BIST_WEN  (A_BIST_WEN),
    .A_BIST_REN  (A_BIST_REN),
    .A_BIST_ADDR (A_BIST_ADDR),
    .A_BIST_DIN  (A_BIST_DIN),
    .A_BIST_BM   (A_BIST_BM),
    .B_BIST_EN   (B_BIST_EN),
    .B_BIST_MEN  (B_BIST_MEN),
    .B_BIST_WEN  (B_BIST_WEN),
    .B_BIST_REN  (B_BIST_REN),
    .B_BIST_ADDR (B_BIST_ADDR),
    .B_BIST_DIN  (B_BIST_DIN),
    .B_BIST_BM   (B_BIST_BM),
    .A_DOUT      (A_DOUT),
    .B_DOUT      (B_DOUT)
  );

  // Memory model: 1-cycle read. fault_mode 1 = bit3 stuck-at-1 at 0x5A,
  // 2 = writing all-ones to 0x10 flips 0x0F, 3 = port-B read of 0xFF gives 0x01.
  logic [DW-1:0] mem [DEPTH];
  int fault_mode = 0;

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = mem[a];
    if (fault_mode == 1 && a == 8'h5A) v = v | 8'h08;
    return v;
  endfunction

  always @(posedge CLK) begin
    if (A_BIST_MEN && A_BIST_WEN) begin
      mem[A_BIST_ADDR] <= A_BIST_DIN;
      if (fault_mode == 2 && A_BIST_ADDR == 8'h10 && A_BIST_DIN == 8'hFF)
        mem[8'h0F] <= ~mem[8'h0F];
    end
    if (A_BIST_MEN && A_BIST_REN) A_DOUT <= rd_val(A_BIST_ADDR);
    if (B_BIST_MEN && B_BIST_REN)
      B_DOUT <= (fault_mode == 3 && B_BIST_ADDR == 8'hFF) ? 8'h01 : rd_val(B_BIST_ADDR);
  end

  // Monotonic access counters
  int a_wr = 0, a_rd = 0, b_wr = 0, b_rd = 0;
  always @(posedge CLK) begin
    if (A_BIST_MEN && A_BIST_WEN) a_wr <= a_wr + 1;
    if (A_BIST_MEN && A_BIST_REN) a_rd <= a_rd + 1;
    if (B_BIST_MEN && B_BIST_WEN) b_wr <= b_wr + 1;
    if (B_BIST_MEN && B_BIST_REN) b_rd <= b_rd + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic start_pulse();
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!DONE && n < NOMINAL + 100) begin
      @(negedge CLK);
      n++;
    end
  endtask

  typedef struct {
    string      name;
    int         fault;
    logic       exp_fail;
    logic [7:0] exp_addr;
    logic [2:0] exp_elem;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n, wa0, ra0, wb0, rb0, acc0;
    logic busy_seen, done_drop;

    vecs[0] = '{"clean",    0, 1'b0, 8'h00, 3'd0};
    vecs[1] = '{"stuck5A",  1, 1'b1, 8'h5A, 3'd1};
    vecs[2] = '{"couple10", 2, 1'b1, 8'h0F, 3'd2};
    vecs[3] = '{"portB_FF", 3, 1'b1, 8'hFF, 3'd6};
    vecs[4] = '{"clean2",   0, 1'b0, 8'h00, 3'd0};

    // Reset state
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst/busy_done_fail", {29'd0, BUSY, DONE, FAIL}, 32'd0);
    chk("rst/fail_addr_elem", {21'd0, FAIL_ADDR, FAIL_ELEM}, 32'd0);
    chk("rst/ctrl", {24'd0, A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
                     B_BIST_EN, B_BIST_MEN, B_BIST_WEN, B_BIST_REN}, 32'd0);
    chk("rst/addr_din", {A_BIST_ADDR, A_BIST_DIN, B_BIST_ADDR, B_BIST_DIN}, 32'd0);
    chk("rst/bm", {16'd0, A_BIST_BM, B_BIST_BM}, 32'h0000FFFF);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Table-driven full runs
    for (int i = 0; i < 5; i++) begin
      fault_mode = vecs[i].fault;
      wa0 = a_wr; ra0 = a_rd; wb0 = b_wr; rb0 = b_rd;
      start_pulse();
      chk({vecs[i].name, "/busy_rise"}, {30'd0, BUSY, A_BIST_EN}, 32'd3);
      chk({vecs[i].name, "/start_clears"}, {20'd0, DONE, FAIL, FAIL_ADDR, FAIL_ELEM}, 32'd0);
      wait_done(n);
      chk({vecs[i].name, "/done_cycles"}, n, NOMINAL);
      chk({vecs[i].name, "/busy_fall"}, {29'd0, BUSY, A_BIST_EN, B_BIST_EN}, 32'd0);
      chk({vecs[i].name, "/fail"}, {31'd0, FAIL}, {31'd0, vecs[i].exp_fail});
      chk({vecs[i].name, "/fail_addr"}, {24'd0, FAIL_ADDR}, {24'd0, vecs[i].exp_addr});
      chk({vecs[i].name, "/fail_elem"}, {29'd0, FAIL_ELEM}, {29'd0, vecs[i].exp_elem});
      chk({vecs[i].name, "/a_writes"}, a_wr - wa0, 5 * DEPTH);
      chk({vecs[i].name, "/a_reads"}, a_rd - ra0, 5 * DEPTH);
      chk({vecs[i].name, "/b_reads"}, b_rd - rb0, DEPTH);
      chk({vecs[i].name, "/b_writes"}, b_wr - wb0, 0);
      repeat (3) @(negedge CLK);
    end

    // START during a run is ignored; only one DONE
    fault_mode = 0;
    start_pulse();
    repeat (1000) @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done(n);
    chk("ignore/done_cycles", n + 1001, NOMINAL);
    busy_seen = 1'b0;
    done_drop = 1'b0;
    repeat (30) begin
      @(negedge CLK);
      if (BUSY) busy_seen = 1'b1;
      if (!DONE) done_drop = 1'b1;
    end
    chk("ignore/no_rerun", {30'd0, busy_seen, done_drop}, 32'd0);

    // RST in the middle of E3
    start_pulse();
    repeat (5 * DEPTH + 100) @(negedge CLK);
    chk("midrst/active_before", {30'd0, A_BIST_MEN, BUSY}, 32'd3);
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst/ctrl_drop", {26'd0, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
                             B_BIST_MEN, B_BIST_WEN, B_BIST_REN}, 32'd0);
    chk("midrst/busy_drop", {29'd0, BUSY, A_BIST_EN, DONE}, 32'd0);
    RST = 1'b0;
    acc0 = a_wr + a_rd + b_wr + b_rd;
    repeat (50) @(negedge CLK);
    chk("midrst/no_access", (a_wr + a_rd + b_wr + b_rd) - acc0, 0);
    chk("midrst/idle", {31'd0, BUSY}, 32'd0);
    wa0 = a_wr;
    start_pulse();
    wait_done(n);
    chk("midrst/rerun_cycles", n, NOMINAL);
    chk("midrst/rerun_fail", {31'd0, FAIL}, 32'd0);
    chk("midrst/rerun_writes", a_wr - wa0, 5 * DEPTH);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
